// File: rtl/inert_spi_serf.sv
// SPI responder standing in for the inertial sensor's gyro path: decodes 16-bit R/W frames,
// keeps a small register file and snapshots the yaw rate at a programmable output data rate.
module inert_spi_serf #(
  parameter logic [15:0] ODR_CYC  = 16'd2048,
  parameter logic [7:0]  WHO_AM_I = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] yaw_rt_in,
  output logic        cfg_done,
  output logic        frm_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Synchronizers come out of reset at the bus idle levels so reset never looks like an edge.
  localparam logic [2:0]  PIN_RST  = 3'b110;
  localparam logic [15:0] ODR_LAST = ODR_CYC - 16'd1;

  logic [2:0] pins;
  logic [2:0] sync_q;
  logic [1:0] edge_reg;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign pins = {SS_n, SCLK, MOSI};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic [1:0] sh_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sh_reg <= {2{PIN_RST[gi]}};
      else     sh_reg <= {sh_reg[0], pins[gi]};
    end
    assign sync_q[gi] = sh_reg[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) edge_reg <= 2'b11;
    else     edge_reg <= sync_q[2:1];
  end

  assign ss_fall   =  edge_reg[1] & ~sync_q[2];
  assign ss_rise   = ~edge_reg[1] &  sync_q[2];
  assign sclk_rise = ~edge_reg[0] &  sync_q[1];
  assign sclk_fall =  edge_reg[0] & ~sync_q[1];

  state_t      state_reg;
  logic [4:0]  bit_cnt_reg;
  logic [15:0] rx_reg;
  logic [15:0] rx_shift;
  logic [7:0]  tx_reg;
  logic        frm_err_reg;

  logic [7:0]  int1_ctrl_reg, ctrl2_reg, ctrl7_reg;
  logic [15:0] yaw_reg;
  logic        int_reg, ovr_reg;
  logic [2:0]  cfg_seen_reg, cfg_seen_next;
  logic        cfg_done_reg;
  logic [15:0] timer_reg;
  logic [7:0]  rd_data;

  logic frame_end, frame_ok, wr_commit, rd_clr, sample_en, tick;

  assign rx_shift = {rx_reg[14:0], sync_q[0]};

  // Address comes from the shifted value so the mux is valid on the 8th rise itself.
  always_comb begin
    rd_data = 8'h00;
    case (rx_shift[6:0])
      7'h0D:   rd_data = int1_ctrl_reg;
      7'h0F:   rd_data = WHO_AM_I;
      7'h11:   rd_data = ctrl2_reg;
      7'h14:   rd_data = ctrl7_reg;
      7'h1E:   rd_data = {6'd0, ovr_reg, int_reg};
      7'h26:   rd_data = yaw_reg[7:0];
      7'h27:   rd_data = yaw_reg[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  assign frame_end = ss_rise && (state_reg != IDLE);
  assign frame_ok  = frame_end && (bit_cnt_reg == 5'd16);
  assign wr_commit = frame_ok && !rx_reg[15];
  assign rd_clr    = frame_ok && rx_reg[15] && (rx_reg[14:8] == 7'h27);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 5'd0;
      rx_reg      <= 16'd0;
      tx_reg      <= 8'd0;
      frm_err_reg <= 1'b0;
    end else begin
      frm_err_reg <= 1'b0;
      if (ss_rise) begin
        if (state_reg != IDLE && bit_cnt_reg != 5'd16) frm_err_reg <= 1'b1;
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (ss_fall) begin
              state_reg   <= CMD;
              bit_cnt_reg <= 5'd0;
              tx_reg      <= 8'd0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_reg      <= rx_shift;
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd7) begin
                state_reg <= DATA;
                tx_reg    <= rx_shift[7] ? rd_data : 8'd0;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_reg <= rx_shift;
              if (bit_cnt_reg != 5'd31) bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            // The fall right after the 8th rise keeps bit 7 on the wire for the 9th rise.
            if (sclk_fall && bit_cnt_reg >= 5'd9) tx_reg <= {tx_reg[6:0], 1'b0};
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cfg_seen_next = cfg_seen_reg;
    if (wr_commit) begin
      case (rx_reg[14:8])
        7'h0D:   cfg_seen_next[0] = 1'b1;
        7'h11:   cfg_seen_next[1] = 1'b1;
        7'h14:   cfg_seen_next[2] = 1'b1;
        default: cfg_seen_next = cfg_seen_reg;
      endcase
    end
  end

  assign sample_en = int1_ctrl_reg[1] && (ctrl2_reg != 8'h00);
  assign tick      = sample_en && (timer_reg == ODR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_ctrl_reg <= 8'd0;
      ctrl2_reg     <= 8'd0;
      ctrl7_reg     <= 8'd0;
      yaw_reg       <= 16'd0;
      int_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
      cfg_seen_reg  <= 3'd0;
      cfg_done_reg  <= 1'b0;
      timer_reg     <= 16'd0;
    end else begin
      if (!sample_en || tick) timer_reg <= 16'd0;
      else                    timer_reg <= timer_reg + 16'd1;

      if (wr_commit) begin
        case (rx_reg[14:8])
          7'h0D:   int1_ctrl_reg <= rx_reg[7:0];
          7'h11:   ctrl2_reg     <= rx_reg[7:0];
          7'h14:   ctrl7_reg     <= rx_reg[7:0];
          default: ;
        endcase
      end
      cfg_seen_reg <= cfg_seen_next;
      cfg_done_reg <= &cfg_seen_next;

      if (rd_clr) begin
        int_reg <= 1'b0;
        ovr_reg <= 1'b0;
      end
      // A tick landing on the clearing frame end keeps INT set but is not an overrun.
      if (tick) begin
        yaw_reg <= yaw_rt_in;
        int_reg <= 1'b1;
        if (int_reg && !rd_clr) ovr_reg <= 1'b1;
      end
    end
  end

  assign MISO     = (state_reg == DATA) ? tx_reg[7] : 1'b0;
  assign INT      = int_reg;
  assign cfg_done = cfg_done_reg;
  assign frm_err  = frm_err_reg;

endmodule

// File: tb/tb_inert_spi_serf.sv
// Bench for inert_spi_serf: a SPI master drives frames, a bus monitor compares each
// completed frame's MISO word against responses predicted by a register-map model.
module tb_inert_spi_serf;

  localparam logic [15:0] ODR = 16'd2048;
  localparam int HP  = 8;
  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic [15:0] yaw_rt_in = 16'h0000;
  logic        MISO, INT, cfg_done, frm_err;

  inert_spi_serf #(.ODR_CYC(ODR), .WHO_AM_I(8'h6A)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .yaw_rt_in(yaw_rt_in), .cfg_done(cfg_done), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int frm_cnt = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int last_rise_cyc = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;

  // Register-map model
  logic [7:0]  m_int1, m_ctrl2, m_ctrl7;
  logic [15:0] m_yaw;
  bit          m_int, m_ovr;

  task automatic model_reset();
    m_int1 = 8'h00; m_ctrl2 = 8'h00; m_ctrl7 = 8'h00;
    m_yaw = 16'h0000; m_int = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    logic [7:0] v;
    case (a)
      7'h0D:   v = m_int1;
      7'h0F:   v = 8'h6A;
      7'h11:   v = m_ctrl2;
      7'h14:   v = m_ctrl7;
      7'h1E:   v = {6'd0, m_ovr, m_int};
      7'h26:   v = m_yaw[7:0];
      7'h27:   v = m_yaw[15:8];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic model_end(input logic [15:0] w);
    if (!w[15]) begin
      if (w[14:8] == 7'h0D) m_int1 = w[7:0];
      if (w[14:8] == 7'h11) m_ctrl2 = w[7:0];
      if (w[14:8] == 7'h14) m_ctrl7 = w[7:0];
    end else if (w[14:8] == 7'h27) begin
      m_int = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic model_tick(input logic [15:0] y);
    if (m_int) m_ovr = 1'b1;
    m_int = 1'b1;
    m_yaw = y;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, input bit close);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      repeat (HP) @(negedge clk);
      SCLK = 1'b1;
      repeat (HP) @(negedge clk);
    end
    if (close) begin
      SS_n = 1'b1;
      last_rise_cyc = cyc;
    end
  endtask

  task automatic xfer(input logic [15:0] w);
    logic [7:0] e;
    e = w[15] ? model_read(w[14:8]) : 8'h00;
    exp_q.push_back({8'h00, e});
    spi_frame(w, 16, 1'b1);
    model_end(w);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic wait_int(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (INT === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Bus monitor: one comparison per complete 16-bit frame.
  initial begin
    logic [15:0] mw, cw, e;
    int n;
    forever begin
      @(negedge SS_n);
      mw = 16'h0; cw = 16'h0; n = 0;
      while (SS_n === 1'b0) begin
        @(posedge SCLK or posedge SS_n);
        if (SS_n === 1'b0) begin
          mw = {mw[14:0], MISO};
          cw = {cw[14:0], MOSI};
          n++;
        end
      end
      if (n == 16) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL frame_%h: got miso 0x%h, required a queued response (none)", cw, mw);
        end else begin
          e = exp_q.pop_front();
          $display("frame cmd=0x%h miso=0x%h expected=0x%h", cw, mw, e);
          check($sformatf("frame_%h", cw), {16'h0, mw}, {16'h0, e});
        end
      end else begin
        $display("frame cmd-bits=0x%h closed after %0d bits (not scored)", cw, n);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int elapsed, t0, f0;
    logic [6:0] a;
    logic [15:0] w;

    model_reset();
    repeat (5) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_int", INT, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    xfer(16'h8F00);
    check("no_frm_err_after_whoami", frm_cnt, 0);

    // Random accesses that avoid the three config registers
    for (int i = 0; i < 8; i++) begin
      a = 7'($urandom_range(0, 127));
      while (a == 7'h0D || a == 7'h11 || a == 7'h14) a = 7'($urandom_range(0, 127));
      w = {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
      xfer(w);
    end
    check("cfg_done_before_cfg", cfg_done, 0);

    yaw_rt_in = 16'hFA3C;
    xfer(16'h0D02);
    xfer(16'h1160);
    elapsed = last_rise_cyc;
    check("cfg_done_after_two", cfg_done, 0);
    xfer(16'h1440);
    check("cfg_done_after_three", cfg_done, 1);
    xfer(16'h8D00);
    xfer(16'h9100);
    xfer(16'h9400);

    wait_int(int'(ODR) + 200, ok);
    check("int_first_tick", ok, 1);
    elapsed = cyc - elapsed;
    n_cmp++;
    if (elapsed < int'(ODR) || elapsed > int'(ODR) + 6) begin
      n_mis++;
      $display("FAIL odr_first_latency: got %0d clk, required %0d..%0d", elapsed, ODR, int'(ODR) + 6);
    end
    t0 = cyc;
    model_tick(16'hFA3C);

    xfer(16'hA600);
    exp_q.push_back({8'h00, model_read(7'h27)});
    spi_frame(16'hA700, 16, 1'b1);
    model_end(16'hA700);
    @(negedge clk);
    check("int_held_1clk_after_ss", INT, 1);
    repeat (3) @(negedge clk);
    check("int_clear_4clk_after_ss", INT, 0);
    repeat (GAP) @(negedge clk);
    xfer(16'h9E00);

    // Overrun: two ticks without service
    yaw_rt_in = 16'h0100;
    wait_until(t0 + int'(ODR) - 1);
    check("int_before_tick2", INT, 0);
    wait_until(t0 + int'(ODR));
    check("int_at_tick2", INT, 1);
    model_tick(16'h0100);
    yaw_rt_in = 16'h0200;
    wait_until(t0 + 2 * int'(ODR) + 1);
    model_tick(16'h0200);
    xfer(16'h9E00);
    xfer(16'hA600);
    xfer(16'hA700);
    xfer(16'h9E00);

    // Aborted frame
    f0 = frm_cnt;
    spi_frame(16'h0D55, 10, 1'b1);
    repeat (GAP) @(negedge clk);
    check("frm_err_single_pulse", frm_cnt, f0 + 1);
    xfer(16'h8D00);

    // Reset in the middle of a read's data phase
    wait_int(int'(ODR) + 200, ok);
    check("int_before_reset", ok, 1);
    spi_frame(16'h8F00, 10, 1'b0);
    repeat (4) @(negedge clk);
    check("miso_mid_data", MISO, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_miso", MISO, 0);
    check("rst_mid_int", INT, 0);
    check("rst_mid_cfg_done", cfg_done, 0);
    @(negedge clk);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    f0 = frm_cnt;
    repeat (5) @(negedge clk);
    xfer(16'h8F00);
    check("no_frm_err_after_reset", frm_cnt, f0);

    repeat (GAP) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
